// File: rtl/mvm_frame_driver.sv
// Streams a 12-word operand frame (x then row-major M) to a multiplier and
// collects the three 16-bit row results it returns.
module mvm_frame_driver (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_en,
    input  logic [3:0]  ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        start,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] res0,
    output logic [15:0] res1,
    output logic [15:0] res2,
    output logic        busy,
    output logic        done,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  buffer [12];
    logic [3:0]  index;
    logic [1:0]  slot;
    logic [15:0] slot0;
    logic [15:0] slot1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SEND;
            SEND: if (out_ready && index == 4'd11) state_next = RECV;
            RECV: if (in_valid && slot == 2'd2) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand buffer only accepts writes while idle so a frame in flight never changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 12; i++) buffer[i] <= '0;
        end else if (state == IDLE && ld_en && ld_addr <= 4'd11) begin
            buffer[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index     <= '0;
            slot      <= '0;
            slot0     <= '0;
            slot1     <= '0;
            res0      <= '0;
            res1      <= '0;
            res2      <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    index <= '0;
                    slot  <= '0;
                end
                SEND: begin
                    if (out_ready) index <= (index == 4'd11) ? 4'd0 : index + 4'd1;
                end
                RECV: begin
                    if (in_valid) begin
                        slot <= slot + 2'd1;
                        case (slot)
                            2'd0: slot0 <= in_data;
                            2'd1: slot1 <= in_data;
                            default: begin
                                // All three results are published on the same edge.
                                res0 <= slot0;
                                res1 <= slot1;
                                res2 <= in_data;
                            end
                        endcase
                    end
                end
                DONE: frame_cnt <= frame_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    assign out_valid = (state == SEND);
    assign out_data  = out_valid ? buffer[index] : 8'd0;
    assign in_ready  = (state == RECV);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule
